// File: rtl/instr_prefetch.sv
// instr_prefetch: fetches 32-bit words over req/ack into a DEPTH-entry {pc, instr} queue for decode
module instr_prefetch #(
  parameter int DEPTH = 4,
  parameter logic [63:0] RESET_PC = 64'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  input  logic        out_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;
  state_t state, state_n;
  logic [63:0] fetch_pc, fetch_pc_n, addr_n;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [63:0] pc_q [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic push, pop;
  assign mem_req = (state == REQ) || (state == KILL);
  assign out_valid = count != '0;
  assign out_instr = out_valid ? instr_q[rd_ptr] : '0;
  assign out_pc = out_valid ? pc_q[rd_ptr] : '0;
  assign pop = out_valid & out_ready & ~redirect;
  assign push = (state == REQ) & mem_ack & ~redirect;
  assign count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
  // mem_addr only moves when a new request is launched, so it is stable while mem_req is high
  always_comb begin
    state_n = state;
    fetch_pc_n = fetch_pc;
    addr_n = mem_addr;
    case (state)
      IDLE:
        if (redirect) fetch_pc_n = redirect_pc;
        else if (count < FULL) begin
          state_n = REQ;
          addr_n = fetch_pc;
        end
      REQ:
        if (redirect) begin
          fetch_pc_n = redirect_pc;
          state_n = mem_ack ? IDLE : KILL;
        end else if (mem_ack) begin
          fetch_pc_n = fetch_pc + 64'd4;
          addr_n = fetch_pc + 64'd4;
          state_n = (count_n < FULL) ? REQ : IDLE;
        end
      KILL: begin
        if (redirect) fetch_pc_n = redirect_pc;
        if (mem_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= fetch_pc_n;
      mem_addr <= addr_n;
      count <= count_n;
      rd_ptr <= redirect ? '0 : rd_ptr + AW'(pop);
      wr_ptr <= redirect ? '0 : wr_ptr + AW'(push);
    end
  always_ff @(posedge clk)
    if (push) begin
      pc_q[wr_ptr] <= fetch_pc;
      instr_q[wr_ptr] <= mem_rdata;
    end
endmodule

// File: doc/instr_prefetch.md
# instr_prefetch

Instruction prefetch queue between the unified byte memory and the instruction decoder. It issues 32-bit instruction reads over a req/ack port, starting at 0x2000 after reset, and buffers up to DEPTH fetched words with their PCs. It presents the words to the decode stage through a valid/ready handshake. A branch redirect from control flushes the queue and restarts fetch at the new target.

## Interface
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 64'h2000: fetch address after reset.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- redirect  in  1  flush queue and restart fetch this cycle.
- redirect_pc  in  64  new fetch address, used as-is with no alignment.
- mem_req  out  1  read request to memory.
- mem_addr  out  64  read byte address.
- mem_ack  in  1  transfer completes at the edge where mem_req & mem_ack.
- mem_rdata  in  32  instruction word; valid when mem_ack is high.
- out_valid  out  1  queue head valid.
- out_instr  out  32  head instruction; 0 when out_valid=0.
- out_pc  out  64  head PC; 0 when out_valid=0.
- out_ready  in  1  decode consumes head when out_valid & out_ready.

## Operation
- Reset values: state IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- Queue: circular buffer of DEPTH {pc, instr} entries with rd_ptr, wr_ptr and count. Pointers wrap modulo DEPTH.
- mem_req = (state==REQ || state==KILL). mem_addr is driven from a register. Once mem_req rises, mem_addr holds until ack; no other change to mem_addr is legal.
- At most one request is outstanding.

State machine:
- IDLE:
  - redirect → fetch_pc=redirect_pc, stay IDLE.
  - Else if count<DEPTH → REQ, with mem_addr=fetch_pc.
- REQ:
  - redirect & !mem_ack → KILL; latch fetch_pc=redirect_pc; clear queue.
  - redirect & mem_ack → drop rdata; clear queue; fetch_pc=redirect_pc; → IDLE.
  - mem_ack only → push {fetch_pc, mem_rdata}; fetch_pc+=4, wrapping mod 2^64.
    - If count_next<DEPTH, stay REQ with mem_addr=new fetch_pc (back-to-back).
    - Else → IDLE.
- KILL: keep the old mem_addr asserted until mem_ack.
  - Data from that ack is discarded.
  - On ack → IDLE.
  - A further redirect in KILL overwrites fetch_pc and clears the queue; stay KILL unless ack.

Queue rules:
- Pop occurs when out_valid & out_ready & !redirect.
- Simultaneous push and pop leaves count unchanged.
- Redirect overrides pop and push; count_next=0.
- A push is never attempted when count==DEPTH. This is guaranteed because requests are issued only with count<DEPTH and count cannot rise while one is outstanding.
- out_valid=(count!=0); out_instr/out_pc come from the entry at rd_ptr.

Reset during operation:
- Asynchronous reset returns everything to the reset values immediately.
- An in-flight memory transaction is abandoned, and mem_req drops combinationally with state.

## Timing
- Reset deassert at edge E0: E1 enters REQ, so mem_req=1 with mem_addr=RESET_PC during cycle 1.
- Ack at edge E: the entry is visible on out_valid/out_instr in the cycle after E. Ack-to-out latency is 1 cycle.
- Back-to-back: with memory acking every cycle and decode always ready, one word is fetched per cycle with no bubbles.
- Redirect sampled at edge E: out_valid=0 in the cycle after E.
  - From IDLE, or REQ with ack: the first request to redirect_pc is presented 1 cycle after E (IDLE→REQ).
  - From KILL: the first request follows 1 cycle after the killed ack.
- Full stall: with count==DEPTH and no pop, mem_req stays 0. A pop at edge E → IDLE→REQ at edge E+1.

## Test plan
- Reset then always-ready decode, memory acking each cycle with rdata=addr[31:0]: out_pc sequence 0x2000, 0x2004, 0x2008…, out_instr matching; mem_req high continuously from cycle 1.
- out_ready=0 with instant ack, DEPTH=4: exactly 4 acks (0x2000–0x200C), then mem_req=0 and out_valid held with out_pc=0x2000. Raising out_ready for 1 cycle → one pop, one new request to 0x2010.
- Redirect to 0x3000 during an outstanding request whose ack comes 3 cycles later: that rdata is discarded, the queue is empty, and the next request goes to 0x3000; first out_pc=0x3000.
- Redirect and mem_ack on the same edge, with a pop also pending: count=0 next cycle, the acked word is absent, and the next mem_addr=redirect_pc.
- Simultaneous push and pop with count=2: count stays 2 and entries remain in order. Pointer wrap is exercised over 3×DEPTH words without loss or duplication.
- fetch_pc=64'hFFFF_FFFF_FFFF_FFFC acked: next mem_addr=0. Asserting reset while mem_req=1 gives mem_req=0, out_valid=0 and mem_addr=0x2000 before the next edge.
